// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//
// Pixel-timing bundle between the VGA raster generator and its consumers
// (icon renderer, world-map renderer, display port).
//
// Signals
//   pixEn       one-clk strobe marking each pixel tick
//   pixCol      current horizontal count, 0..H_TOTAL-1
//   pixRow      current vertical count, 0..V_TOTAL-1
//   video_on    high while the current pixel is in the visible area
//   horiz_sync  active-low horizontal sync
//   vert_sync   active-low vertical sync
//   frameStart  one-clk strobe when the raster wraps to (0,0)
//
// Modports
//   master  the timing generator, which drives every signal
//   slave   a consumer, which only observes
//
// Handshake: this bundle has a producer strobe and no ready. pixEn acts as
// "valid" for a new pixel coordinate. A consumer cannot stall the raster, so
// it must accept every pixel. Between strobes, all other signals hold their
// values, so a consumer may sample them on any clk of the pixel.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic       pixEn;
    logic [9:0] pixCol;
    logic [9:0] pixRow;
    logic       video_on;
    logic       horiz_sync;
    logic       vert_sync;
    logic       frameStart;

    modport master (
        output pixEn,
        output pixCol,
        output pixRow,
        output video_on,
        output horiz_sync,
        output vert_sync,
        output frameStart
    );

    modport slave (
        input pixEn,
        input pixCol,
        input pixRow,
        input video_on,
        input horiz_sync,
        input vert_sync,
        input frameStart
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Generates VGA raster timing from the system clock. With the default
// parameters this is 640x480 at 60 Hz, using a 25 MHz pixel rate derived
// from 100 MHz.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-low reset
//   pix    vga_timing_gen_if.master. This carries pixEn, pixCol, pixRow,
//          video_on, horiz_sync, vert_sync and frameStart.
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
//
// CLK_DIV legal range: 1..16.
// The H and V totals must both fit in 10 bits.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  pix
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Width of the divider counter. It is kept at least 1 bit wide so that
    // CLK_DIV=1 still has a legal vector.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt;
    logic             tick;

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] hNext;
    logic [9:0] vNext;
    logic       rasterWrap;

    logic pixEnQ;
    logic videoOnQ;
    logic hSyncQ;
    logic vSyncQ;
    logic frameStartQ;

    // The pixel tick is the last clk of each divider period. The counters and
    // the pixEn strobe both update on that edge, so pixEn is high during the
    // first clk in which the new coordinate is visible.
    assign tick = (divCnt == DIV_LAST);

    // Raster position that the next tick will move to.
    always_comb begin
        hNext = hcnt + 10'd1;
        vNext = vcnt;
        if (hcnt == H_LAST) begin
            hNext = 10'd0;
            if (vcnt == V_LAST) begin
                vNext = 10'd0;
            end else begin
                vNext = vcnt + 10'd1;
            end
        end
    end

    assign rasterWrap = (hcnt == H_LAST) && (vcnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt <= '0;
        end else if (tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + DIV_W'(1);
        end
    end

    // The counters and status flags change only on a tick. The status flags
    // are computed from the next position, so they stay cycle-aligned with
    // pixCol and pixRow. During reset, pixel (0,0) is held with video_on=0,
    // which blanks the first pixel of the first frame once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            videoOnQ <= 1'b0;
            hSyncQ   <= 1'b1;
            vSyncQ   <= 1'b1;
        end else if (tick) begin
            hcnt     <= hNext;
            vcnt     <= vNext;
            videoOnQ <= (hNext < H_VIS) && (vNext < V_VIS);
            hSyncQ   <= !((hNext >= H_SYNC_START) && (hNext < H_SYNC_END));
            vSyncQ   <= !((vNext >= V_SYNC_START) && (vNext < V_SYNC_END));
        end
    end

    // Both strobes last exactly one clk. frameStart can only follow a wrap
    // from the last pixel, so it never fires when reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixEnQ      <= 1'b0;
            frameStartQ <= 1'b0;
        end else begin
            pixEnQ      <= tick;
            frameStartQ <= tick && rasterWrap;
        end
    end

    assign pix.pixEn      = pixEnQ;
    assign pix.pixCol     = hcnt;
    assign pix.pixRow     = vcnt;
    assign pix.video_on   = videoOnQ;
    assign pix.horiz_sync = hSyncQ;
    assign pix.vert_sync  = vSyncQ;
    assign pix.frameStart = frameStartQ;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives three generator instances:
//   dutA  default 640x480 geometry, CLK_DIV=4.
//         Checks reset state, first-tick latency and line timing through
//         the second line.
//   dutB  small geometry, CLK_DIV=3.
//         Covers whole frames, with a mid-frame async reset and random
//         async resets.
//   dutC  the same small geometry, CLK_DIV=1.
//         Shares its reset with dutB.
//
// The reference model counts clk edges since reset release. It derives the
// whole output vector from that count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int div;
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
    } geom_t;

    typedef struct {
        int pixEn, col, row, von, hs, vs, fs;
    } obs_t;

    typedef struct {
        int   k;      // clk edges since reset release
        obs_t e;      // expected outputs after that edge
    } vec_t;

    localparam int NV = 15;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int k_a;
    int k_b;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) k_a <= 0;
        else        k_a <= k_a + 1;
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) k_b <= 0;
        else        k_b <= k_b + 1;
    end

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .pix(if_a)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix(if_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_c (
        .clk(clk), .reset(rst_b), .pix(if_c)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check1(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, obs_t a, obs_t e);
        check1({tag, ".pixEn"},      a.pixEn, e.pixEn);
        check1({tag, ".pixCol"},     a.col,   e.col);
        check1({tag, ".pixRow"},     a.row,   e.row);
        check1({tag, ".video_on"},   a.von,   e.von);
        check1({tag, ".horiz_sync"}, a.hs,    e.hs);
        check1({tag, ".vert_sync"},  a.vs,    e.vs);
        check1({tag, ".frameStart"}, a.fs,    e.fs);
    endtask

    function automatic obs_t sample(logic pe, logic [9:0] c, logic [9:0] r,
                                    logic v, logic h, logic vs, logic f);
        obs_t o;
        o.pixEn = int'(pe);
        o.col   = int'(c);
        o.row   = int'(r);
        o.von   = int'(v);
        o.hs    = int'(h);
        o.vs    = int'(vs);
        o.fs    = int'(f);
        return o;
    endfunction

    function automatic obs_t obs_a();
        return sample(if_a.pixEn, if_a.pixCol, if_a.pixRow, if_a.video_on,
                      if_a.horiz_sync, if_a.vert_sync, if_a.frameStart);
    endfunction

    function automatic obs_t obs_b();
        return sample(if_b.pixEn, if_b.pixCol, if_b.pixRow, if_b.video_on,
                      if_b.horiz_sync, if_b.vert_sync, if_b.frameStart);
    endfunction

    function automatic obs_t obs_c();
        return sample(if_c.pixEn, if_c.pixCol, if_c.pixRow, if_c.video_on,
                      if_c.horiz_sync, if_c.vert_sync, if_c.frameStart);
    endfunction

    // ---------------- reference model ----------------
    // The model takes k, the number of clk edges since reset release; k=0
    // means in reset or not yet clocked.
    //   Tick count: n = k / div.
    //   Raster position: n modulo the frame size, split into column and row.
    // Reset values fall out naturally at k=0, because (0,0) is outside both
    // sync windows.
    function automatic obs_t model(geom_t g, int k);
        obs_t e;
        int ht, vt, n, p, col, row;
        ht  = g.ha + g.hfp + g.hs + g.hbp;
        vt  = g.va + g.vfp + g.vs + g.vbp;
        n   = k / g.div;
        p   = n % (ht * vt);
        col = p % ht;
        row = p / ht;
        e.pixEn = (k > 0 && (k % g.div) == 0) ? 1 : 0;
        e.col   = col;
        e.row   = row;
        e.von   = (n > 0 && col < g.ha && row < g.va) ? 1 : 0;
        e.hs    = (col >= g.ha + g.hfp && col < g.ha + g.hfp + g.hs) ? 0 : 1;
        e.vs    = (row >= g.va + g.vfp && row < g.va + g.vfp + g.vs) ? 0 : 1;
        e.fs    = (e.pixEn == 1 && p == 0) ? 1 : 0;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    geom_t g_a, g_b, g_c;
    obs_t  rst_exp;

    // Drops rst_b between clock edges and checks that both small DUTs are
    // at their reset values before the next edge. It then releases reset at
    // a negedge.
    task automatic async_reset_b(string tag, int hold);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        cmp({tag, ".B"}, obs_b(), rst_exp);
        cmp({tag, ".C"}, obs_c(), rst_exp);
        repeat (hold) @(negedge clk);
        cmp({tag, ".B.held"}, obs_b(), rst_exp);
        rst_b = 1'b1;
    endtask

    vec_t vecs[NV];

    initial begin
        g_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        g_b = '{3, 12, 3, 5, 4, 5, 2, 2, 3};
        g_c = '{1, 12, 3, 5, 4, 5, 2, 2, 3};
        rst_exp = '{0, 0, 0, 0, 1, 1, 0};

        // Hand-computed checkpoints for dutA:
        //   k          edges since release
        //   {pixEn, col, row, video_on, hsync, vsync, frameStart}
        vecs[0]  = '{1,    '{0, 0,   0, 0, 1, 1, 0}};
        vecs[1]  = '{3,    '{0, 0,   0, 0, 1, 1, 0}};
        vecs[2]  = '{4,    '{1, 1,   0, 1, 1, 1, 0}};
        vecs[3]  = '{5,    '{0, 1,   0, 1, 1, 1, 0}};
        vecs[4]  = '{2556, '{1, 639, 0, 1, 1, 1, 0}};
        vecs[5]  = '{2559, '{0, 639, 0, 1, 1, 1, 0}};
        vecs[6]  = '{2560, '{1, 640, 0, 0, 1, 1, 0}};
        vecs[7]  = '{2623, '{0, 655, 0, 0, 1, 1, 0}};
        vecs[8]  = '{2624, '{1, 656, 0, 0, 0, 1, 0}};
        vecs[9]  = '{3004, '{1, 751, 0, 0, 0, 1, 0}};
        vecs[10] = '{3008, '{1, 752, 0, 0, 1, 1, 0}};
        vecs[11] = '{3196, '{1, 799, 0, 0, 1, 1, 0}};
        vecs[12] = '{3200, '{1, 0,   1, 1, 1, 1, 0}};
        vecs[13] = '{3201, '{0, 0,   1, 1, 1, 1, 0}};
        vecs[14] = '{5824, '{1, 656, 1, 0, 0, 1, 0}};

        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset held for 10 clks; every DUT must sit at its reset values.
        repeat (10) @(negedge clk);
        cmp("reset.A", obs_a(), rst_exp);
        cmp("reset.B", obs_b(), rst_exp);
        cmp("reset.C", obs_c(), rst_exp);

        // ---- dutA: table-driven walk, plus a model check on every clk ----
        rst_a = 1'b1;
        begin
            int idx;
            int budget;
            idx    = 0;
            budget = 0;
            while (idx < NV && budget < 7000) begin
                @(negedge clk);
                budget++;
                cmp("modelA", obs_a(), model(g_a, k_a));
                if (k_a == vecs[idx].k) begin
                    cmp($sformatf("vecA[%0d]", idx), obs_a(), vecs[idx].e);
                    idx++;
                end
            end
            check1("vecA.reached", idx, NV);
        end

        // ---- dutB/dutC: free run, with a deterministic mid-frame reset ----
        rst_b = 1'b1;
        begin
            int found;
            found = 0;
            for (int i = 0; i < 2000 && found == 0; i++) begin
                @(negedge clk);
                cmp("modelB", obs_b(), model(g_b, k_b));
                cmp("modelC", obs_c(), model(g_c, k_c_of(k_b)));
                if (if_b.pixCol == 10'd7 && if_b.pixRow == 10'd3) found = 1;
            end
            check1("midframe.reached", found, 1);
        end
        async_reset_b("midreset", 3);

        // ---- random run with occasional async resets ----
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            cmp("modelB", obs_b(), model(g_b, k_b));
            cmp("modelC", obs_c(), model(g_c, k_c_of(k_b)));
            if ($urandom_range(0, 1499) == 0) begin
                async_reset_b("rndreset", int'($urandom_range(1, 5)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // dutC shares reset and clock with dutB, so it sees the same edge count.
    function automatic int k_c_of(int k);
        return k;
    endfunction

endmodule
